dcache_writeback_unit: RTL and testbench

Downstream drain stage of the write-back dcache controller. It accepts one evicted dirty cache line (address plus full line data) per handshake and serialises it to main memory as XLEN-wide word stores, one store outstanding at a time. It also reports a hazard when a CPU request targets the line currently being drained, so the controller can stall instead of refilling stale data.

---
 rtl/dcache_pkg.sv | 48 ++++
 rtl/dcache_writeback_unit.sv | 115 +++++++++++
 tb/tb_dcache_writeback_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the write-back dcache controller.
// Contents:
//   - geometry constants (line width, word width, physical address width,
//     line offset width, words per line)
//   - memory request size encoding for word stores
//   - writeback_t: an evicted line (address + full line data)
//   - dcache_wb_state_t: states of the write-back drain unit
//   - cpu_to_memory_address(): aligns an address to a request size
package dcache_pkg;

  localparam int DCACHE_LINE_WIDTH   = 128;
  localparam int RISCV_XLEN          = 32;
  localparam int RISCV_PLEN          = 34;
  localparam int DCACHE_OFFSET_WIDTH = 4;

  localparam int NUMBER_OF_WORDS_IN_CACHE_BLOCK = DCACHE_LINE_WIDTH / RISCV_XLEN;

  localparam logic [2:0] MEMORY_REQUEST_SIZE_FOUR_BYTES = 3'b010;
  localparam logic [2:0] MEMORY_REQUEST_SIZE_LINE       = 3'b111;

  typedef struct packed {
    logic [RISCV_PLEN-1:0]        address;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } writeback_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_REQ,
    WB_WAIT_DONE
  } dcache_wb_state_t;

  // Sizes 0..3 clear log2(bytes) low bits; the line size clears the whole
  // in-line byte offset.
  function automatic logic [RISCV_PLEN-1:0] cpu_to_memory_address(
    input logic [RISCV_PLEN-1:0] addr,
    input logic [2:0]            size
  );
    logic [RISCV_PLEN-1:0] aligned;
    int                    n_clear;
    aligned = addr;
    n_clear = (size == MEMORY_REQUEST_SIZE_LINE) ? DCACHE_OFFSET_WIDTH : int'(size);
    for (int i = 0; i < DCACHE_OFFSET_WIDTH; i++) begin
      if (i < n_clear) aligned[i] = 1'b0;
    end
    return aligned;
  endfunction

endpackage

// File: rtl/dcache_writeback_unit.sv
// Drain stage for evicted dirty dcache lines.
// Accepts one line per wb_valid_i/wb_ready_o handshake and writes it to
// memory as ascending XLEN-wide stores, one outstanding at a time.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   wb_valid_i/wb_ready_o         line handshake; wb_address_i, wb_data_i
//   wb_done_o                     pulse in the cycle the last store returns
//   busy_o                        a line is held
//   hazard_address_i/hazard_hit_o CPU lookup address hits the held line
//   mem_req_*                     word store request (valid/ready/addr/data/size)
//   mem_rtrn_valid_i              store completion from memory
//
// state        | meaning
// WB_IDLE      | no line held, ready for a new one
// WB_REQ       | store request for word_idx presented, waiting for ack
// WB_WAIT_DONE | store acked, waiting for memory completion
module dcache_writeback_unit
  import dcache_pkg::*;
#(
  parameter int LINE_WIDTH   = DCACHE_LINE_WIDTH,
  parameter int XLEN         = RISCV_XLEN,
  parameter int PLEN         = RISCV_PLEN,
  parameter int OFFSET_WIDTH = DCACHE_OFFSET_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic [PLEN-1:0]       wb_address_i,
  input  logic [LINE_WIDTH-1:0] wb_data_i,
  output logic                  wb_done_o,
  output logic                  busy_o,
  input  logic [PLEN-1:0]       hazard_address_i,
  output logic                  hazard_hit_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [PLEN-1:0]       mem_req_address_o,
  output logic [XLEN-1:0]       mem_req_data_o,
  output logic [2:0]            mem_req_size_o,
  input  logic                  mem_rtrn_valid_i
);

  localparam int WORDS  = NUMBER_OF_WORDS_IN_CACHE_BLOCK;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int BYTE_SH = $clog2(XLEN / 8);

  dcache_wb_state_t state_q, state_d;
  writeback_t       line_q, line_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic             idle_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= WB_IDLE;
      line_q     <= '0;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      word_idx_q <= word_idx_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    word_idx_d      = word_idx_q;
    idle_ready      = 1'b0;
    mem_req_valid_o = 1'b0;
    wb_done_o       = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        idle_ready = 1'b1;
        if (wb_valid_i) begin
          line_d.address = cpu_to_memory_address(wb_address_i, MEMORY_REQUEST_SIZE_LINE);
          line_d.data    = wb_data_i;
          word_idx_d     = '0;
          state_d        = WB_REQ;
        end
      end
      WB_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = WB_WAIT_DONE;
      end
      WB_WAIT_DONE: begin
        if (mem_rtrn_valid_i) begin
          if (word_idx_q == IDX_W'(WORDS - 1)) begin
            wb_done_o = 1'b1;
            state_d   = WB_IDLE;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
            state_d    = WB_REQ;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // The state register already sits in IDLE while reset is held; gate ready
  // so the controller never sees a handshake during reset.
  assign wb_ready_o = idle_ready && rst_ni;
  assign busy_o     = (state_q != WB_IDLE);

  assign hazard_hit_o = busy_o &&
    (hazard_address_i[PLEN-1:OFFSET_WIDTH] == line_q.address[PLEN-1:OFFSET_WIDTH]);

  assign mem_req_address_o = line_q.address + (PLEN'(word_idx_q) << BYTE_SH);
  assign mem_req_data_o    = line_q.data[word_idx_q*XLEN +: XLEN];
  assign mem_req_size_o    = MEMORY_REQUEST_SIZE_FOUR_BYTES;

  logic unused_hazard_offset;
  assign unused_hazard_offset = ^hazard_address_i[OFFSET_WIDTH-1:0];

endmodule

// File: tb/tb_dcache_writeback_unit.sv
module tb_dcache_writeback_unit;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          wb_valid_i;
  logic          wb_ready_o;
  logic [33:0]   wb_address_i;
  logic [127:0]  wb_data_i;
  logic          wb_done_o;
  logic          busy_o;
  logic [33:0]   hazard_address_i;
  logic          hazard_hit_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [33:0]   mem_req_address_o;
  logic [31:0]   mem_req_data_o;
  logic [2:0]    mem_req_size_o;
  logic          mem_rtrn_valid_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  dcache_writeback_unit dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .wb_valid_i        (wb_valid_i),
    .wb_ready_o        (wb_ready_o),
    .wb_address_i      (wb_address_i),
    .wb_data_i         (wb_data_i),
    .wb_done_o         (wb_done_o),
    .busy_o            (busy_o),
    .hazard_address_i  (hazard_address_i),
    .hazard_hit_o      (hazard_hit_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_req_address_o (mem_req_address_o),
    .mem_req_data_o    (mem_req_data_o),
    .mem_req_size_o    (mem_req_size_o),
    .mem_rtrn_valid_i  (mem_rtrn_valid_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Entered just after the edge that put the unit in REQ for this word.
  // stall: cycles with ready low; spur: spurious return pulse in REQ first.
  task automatic do_word(input logic [33:0] ea, input logic [31:0] ed, input int stall,
                         input bit spur, input bit last, input bit hz_exp);
    mem_req_ready_i = 1'b0;
    if (spur) begin
      mem_rtrn_valid_i = 1'b1;
      #3;
      chk("spur_done", wb_done_o, 0);
      next_cycle();
      mem_rtrn_valid_i = 1'b0;
      #3;
      chk("spur_valid", mem_req_valid_o, 1);
      chk("spur_addr", mem_req_address_o, ea);
      chk("spur_data", mem_req_data_o, ed);
      next_cycle();
    end
    for (int i = 0; i < stall; i++) begin
      #3;
      chk("stall_valid", mem_req_valid_o, 1);
      chk("stall_addr", mem_req_address_o, ea);
      chk("stall_data", mem_req_data_o, ed);
      next_cycle();
    end
    mem_req_ready_i = 1'b1;
    #3;
    chk("req_valid", mem_req_valid_o, 1);
    chk("req_addr", mem_req_address_o, ea);
    chk("req_data", mem_req_data_o, ed);
    chk("req_size", mem_req_size_o, 3'b010);
    chk("req_busy", busy_o, 1);
    chk("req_ready", wb_ready_o, 0);
    chk("req_hazard", hazard_hit_o, hz_exp);
    next_cycle();
    mem_req_ready_i  = 1'b0;
    mem_rtrn_valid_i = 1'b1;
    #3;
    chk("wait_valid", mem_req_valid_o, 0);
    chk("wait_done", wb_done_o, last);
    chk("wait_hazard", hazard_hit_o, hz_exp);
    chk("wait_ready", wb_ready_o, 0);
    next_cycle();
    mem_rtrn_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni           = 1'b0;
    wb_valid_i       = 1'b0;
    wb_address_i     = '0;
    wb_data_i        = '0;
    hazard_address_i = '0;
    mem_req_ready_i  = 1'b0;
    mem_rtrn_valid_i = 1'b0;

    // Reset values
    #12;
    chk("rst_ready", wb_ready_o, 0);
    chk("rst_valid", mem_req_valid_o, 0);
    chk("rst_done", wb_done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_hazard", hazard_hit_o, 0);
    next_cycle();
    rst_ni = 1'b1;
    #2;
    chk("post_rst_ready", wb_ready_o, 1);
    next_cycle();

    // Spurious return in IDLE
    mem_rtrn_valid_i = 1'b1;
    #2;
    chk("idle_spur_done", wb_done_o, 0);
    next_cycle();
    mem_rtrn_valid_i = 1'b0;
    #2;
    chk("idle_spur_busy", busy_o, 0);
    chk("idle_spur_ready", wb_ready_o, 1);
    chk("idle_spur_valid", mem_req_valid_o, 0);
    next_cycle();

    // Basic drain with hazard checks
    wb_valid_i       = 1'b1;
    wb_address_i     = 34'h0_8000_1234;
    wb_data_i        = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    hazard_address_i = 34'h0_8000_123C;
    #2;
    chk("a_accept_ready", wb_ready_o, 1);
    chk("a_idle_hazard", hazard_hit_o, 0);
    next_cycle();
    wb_valid_i = 1'b0;
    #1;
    chk("a_hazard_hit", hazard_hit_o, 1);
    hazard_address_i = 34'h0_8000_1240;
    #1;
    chk("a_hazard_miss", hazard_hit_o, 0);
    hazard_address_i = 34'h0_8000_123C;
    do_word(34'h0_8000_1230, 32'hAAAAAAAA, 0, 0, 0, 1);
    do_word(34'h0_8000_1234, 32'hBBBBBBBB, 0, 0, 0, 1);
    do_word(34'h0_8000_1238, 32'hCCCCCCCC, 0, 0, 0, 1);
    do_word(34'h0_8000_123C, 32'hDDDDDDDD, 0, 0, 1, 1);
    #2;
    chk("a_end_done", wb_done_o, 0);
    chk("a_end_busy", busy_o, 0);
    chk("a_end_ready", wb_ready_o, 1);
    chk("a_end_hazard", hazard_hit_o, 0);
    hazard_address_i = '0;
    next_cycle();

    // Backpressure on word 2, spurious return in REQ, busy rejection
    wb_valid_i   = 1'b1;
    wb_address_i = 34'h0_0000_2008;
    wb_data_i    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    next_cycle();
    wb_address_i = 34'h0_0000_4000;
    wb_data_i    = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
    do_word(34'h0_0000_2000, 32'h11111111, 0, 0, 0, 0);
    do_word(34'h0_0000_2004, 32'h22222222, 0, 1, 0, 0);
    do_word(34'h0_0000_2008, 32'h33333333, 5, 0, 0, 0);
    do_word(34'h0_0000_200C, 32'h44444444, 0, 0, 1, 0);
    #2;
    chk("b_after_done_ready", wb_ready_o, 1);
    next_cycle();
    wb_valid_i = 1'b0;
    do_word(34'h0_0000_4000, 32'h55555555, 0, 0, 0, 0);
    do_word(34'h0_0000_4004, 32'h66666666, 0, 0, 0, 0);
    do_word(34'h0_0000_4008, 32'h77777777, 0, 0, 0, 0);
    do_word(34'h0_0000_400C, 32'h88888888, 0, 0, 1, 0);
    #2;
    chk("c_end_busy", busy_o, 0);
    next_cycle();

    // Reset mid-drain after word 1 is acked
    wb_valid_i       = 1'b1;
    wb_address_i     = 34'h0_8000_1230;
    wb_data_i        = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    hazard_address_i = 34'h0_8000_1230;
    next_cycle();
    wb_valid_i = 1'b0;
    do_word(34'h0_8000_1230, 32'hAAAAAAAA, 0, 0, 0, 1);
    mem_req_ready_i = 1'b1;
    #2;
    chk("r_word1_addr", mem_req_address_o, 34'h0_8000_1234);
    next_cycle();
    mem_req_ready_i = 1'b0;
    #1;
    chk("r_wait_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("r_busy", busy_o, 0);
    chk("r_valid", mem_req_valid_o, 0);
    chk("r_ready", wb_ready_o, 0);
    chk("r_done", wb_done_o, 0);
    chk("r_hazard", hazard_hit_o, 0);
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
    mem_rtrn_valid_i = 1'b1;
    #2;
    chk("r_late_rtrn_done", wb_done_o, 0);
    next_cycle();
    mem_rtrn_valid_i = 1'b0;
    #2;
    chk("r_late_busy", busy_o, 0);
    chk("r_late_valid", mem_req_valid_o, 0);
    chk("r_late_ready", wb_ready_o, 1);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
